// File: rtl/event_stretcher_pkg.sv
// Shared state encoding and sizing helpers for the event stretcher.
package event_stretcher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // A one-cycle phase still needs a 1-bit counter so the compare logic stays uniform.
   function automatic int cnt_width(input int hi, input int lo);
      int m;
      m = (hi > lo) ? hi : lo;
      return (clog2(m) < 1) ? 1 : clog2(m);
   endfunction

endpackage

// File: rtl/event_stretcher_sat_counter.sv
// Up/down counter that saturates at its maximum and raises a sticky overflow flag.
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   input  logic         clr_overflow,
   output logic [W-1:0] value,
   output logic         overflow
);

   localparam logic [W-1:0] MAX = '1;

   logic sat;

   assign sat = inc && !dec && (value == MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value    <= '0;
         overflow <= 1'b0;
      end else begin
         if (inc && !dec && !sat)
            value <= value + 1'b1;
         else if (dec && !inc)
            value <= value - 1'b1;

         // A drop in the same cycle as a clear must remain visible.
         if (sat)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/event_stretcher.sv
// Stretches single-cycle event strobes into HIGH/LOW-timed pulses, queueing bursts.
//  state | meaning
//  IDLE  | output low, nothing queued
//  HIGH  | sigout held high, cnt counts down the high phase
//  GAP   | sigout held low, cnt counts down the minimum low phase
module event_stretcher
   import event_stretcher_pkg::*;
#(
   parameter int HIGH_CYCLES = 4,
   parameter int LOW_CYCLES  = 4,
   parameter int PEND_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              evt_in,
   input  logic              enable,
   input  logic              clr_overflow,
   output logic              sigout,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int CNT_W = cnt_width(HIGH_CYCLES, LOW_CYCLES);
   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             start;
   logic             direct;
   logic             inc;
   logic             dec;
   logic             have_pend;

   assign accept    = evt_in & enable;
   assign have_pend = (pending != '0);
   assign start     = ((state == IDLE) || ((state == GAP) && (cnt == '0))) &&
                      (accept || have_pend);
   assign direct    = start && !have_pend;
   assign inc       = accept && !direct;
   assign dec       = start && have_pend;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         sigout <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= HIGH;
                  cnt    <= HIGH_LOAD;
                  sigout <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            HIGH: begin
               if (cnt == '0) begin
                  state  <= GAP;
                  cnt    <= LOW_LOAD;
                  sigout <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               // Queued pulses restart straight from the last gap cycle, no idle bubble.
               if (start) begin
                  state  <= HIGH;
                  cnt    <= HIGH_LOAD;
                  sigout <= 1'b1;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               sigout <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(
      .W (PEND_W)
   ) u_pend (
      .clk          (clk),
      .reset        (reset),
      .inc          (inc),
      .dec          (dec),
      .clr_overflow (clr_overflow),
      .value        (pending),
      .overflow     (overflow)
   );

endmodule

// File: tb/tb_event_stretcher.sv
// Scoreboard bench for event_stretcher: a pulse-schedule model predicts every cycle's outputs.
module tb_event_stretcher;

   typedef struct packed {
      logic       s;
      logic       b;
      logic [1:0] p;
      logic       o;
   } obs_t;

   logic       clk;
   logic       reset;
   logic       evt_in;
   logic       enable;
   logic       clr_overflow;
   logic       sigout;
   logic       busy;
   logic [1:0] pending;
   logic       overflow;

   int   checks;
   int   failures;
   obs_t exp_q[$];
   bit   ev[0:63];
   bit   en[0:63];
   bit   cl[0:63];

   event_stretcher #(
      .HIGH_CYCLES (4),
      .LOW_CYCLES  (4),
      .PEND_W      (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .evt_in       (evt_in),
      .enable       (enable),
      .clr_overflow (clr_overflow),
      .sigout       (sigout),
      .busy         (busy),
      .pending      (pending),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_plan();
      for (int i = 0; i < 64; i++) begin
         ev[i] = 1'b0;
         en[i] = 1'b1;
         cl[i] = 1'b0;
      end
      exp_q.delete();
   endtask

   // Pulse-level model: event at edge t starts at max(t, previous start + 8); at most 3 wait.
   task automatic plan(input int n);
      int   starts[$];
      int   last;
      bit   ov;
      obs_t e;
      last = -100;
      ov   = 1'b0;
      for (int t = 1; t <= n; t++) begin
         bit drop;
         int s;
         int q;
         drop = 1'b0;
         if (ev[t-1] && en[t-1]) begin
            s = (t > last + 8) ? t : last + 8;
            q = 0;
            foreach (starts[i]) if (starts[i] > t) q++;
            if (s > t && q == 3) drop = 1'b1;
            else begin
               starts.push_back(s);
               last = s;
            end
         end
         if (drop) ov = 1'b1;
         else if (cl[t-1]) ov = 1'b0;
         e = '0;
         q = 0;
         foreach (starts[i]) begin
            if (starts[i] <= t && t < starts[i] + 4) e.s = 1'b1;
            if (starts[i] <= t && t < starts[i] + 8) e.b = 1'b1;
            if (starts[i] > t) q++;
         end
         e.p = 2'(q);
         e.o = ov;
         exp_q.push_back(e);
      end
   endtask

   task automatic apply(input int k);
      evt_in       = ev[k];
      enable       = en[k];
      clr_overflow = cl[k];
   endtask

   task automatic do_reset();
      evt_in       = 1'b0;
      enable       = 1'b1;
      clr_overflow = 1'b0;
      reset        = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      obs_t got;
      do_reset();
      got = {sigout, busy, pending, overflow};
      checks++;
      if (got !== 5'b0) begin
         failures++;
         $display("FAIL reset_state got=%b want=00000", got);
      end
   endtask

   task automatic test_single();
      obs_t got, want;
      do_reset();
      clear_plan();
      ev[0] = 1'b1;
      plan(12);
      @(posedge clk); #1 apply(0);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         got  = {sigout, busy, pending, overflow};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL single edge=%0d got(s,b,p,o)=%b want=%b", k, got, want);
         end
         apply(k);
      end
   endtask

   task automatic test_burst_queue();
      obs_t got, want;
      do_reset();
      clear_plan();
      for (int i = 0; i < 3; i++) ev[i] = 1'b1;
      plan(28);
      @(posedge clk); #1 apply(0);
      for (int k = 1; k <= 28; k++) begin
         @(posedge clk); #1;
         got  = {sigout, busy, pending, overflow};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL burst3 edge=%0d got(s,b,p,o)=%b want=%b", k, got, want);
         end
         apply(k);
      end
   endtask

   task automatic test_overflow();
      obs_t got, want;
      do_reset();
      clear_plan();
      for (int i = 0; i < 6; i++) ev[i] = 1'b1;
      cl[40] = 1'b1;
      plan(44);
      @(posedge clk); #1 apply(0);
      for (int k = 1; k <= 44; k++) begin
         @(posedge clk); #1;
         got  = {sigout, busy, pending, overflow};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL overflow edge=%0d got(s,b,p,o)=%b want=%b", k, got, want);
         end
         apply(k);
      end
   endtask

   task automatic test_enable();
      obs_t got, want;
      do_reset();
      clear_plan();
      en[0] = 1'b0;
      ev[0] = 1'b1;
      ev[4] = 1'b1;
      for (int i = 6; i < 20; i++) en[i] = 1'b0;
      ev[8] = 1'b1;
      plan(20);
      @(posedge clk); #1 apply(0);
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         got  = {sigout, busy, pending, overflow};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL enable edge=%0d got(s,b,p,o)=%b want=%b", k, got, want);
         end
         apply(k);
      end
   endtask

   task automatic test_async_reset();
      obs_t got, want;
      do_reset();
      clear_plan();
      for (int i = 0; i < 6; i++) ev[i] = 1'b1;
      plan(10);
      @(posedge clk); #1 apply(0);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         got  = {sigout, busy, pending, overflow};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL pre_reset edge=%0d got(s,b,p,o)=%b want=%b", k, got, want);
         end
         apply(k);
      end
      // Mid-HIGH with two queued and overflow set; must clear without a clock edge.
      #2 reset = 1'b1;
      #1;
      got = {sigout, busy, pending, overflow};
      checks++;
      if (got !== 5'b0) begin
         failures++;
         $display("FAIL async_reset got(s,b,p,o)=%b want=00000", got);
      end
      evt_in = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      clear_plan();
      ev[0] = 1'b1;
      plan(10);
      apply(0);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         got  = {sigout, busy, pending, overflow};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL post_reset edge=%0d got(s,b,p,o)=%b want=%b", k, got, want);
         end
         apply(k);
      end
   endtask

   task automatic test_back_to_back();
      obs_t got, want;
      do_reset();
      clear_plan();
      ev[0] = 1'b1;
      ev[8] = 1'b1;
      plan(20);
      @(posedge clk); #1 apply(0);
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         got  = {sigout, busy, pending, overflow};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL back_to_back edge=%0d got(s,b,p,o)=%b want=%b", k, got, want);
         end
         apply(k);
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      evt_in       = 1'b0;
      enable       = 1'b1;
      clr_overflow = 1'b0;
      test_reset();
      test_single();
      test_burst_queue();
      test_overflow();
      test_enable();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
